// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM block family: default counter width and
// the capture FSM state encoding.
package pwm_pkg;

   localparam int unsigned PWM_RESOLUTION = 32;
   localparam int unsigned PWMC_STATE_W   = 2;

   localparam logic [PWMC_STATE_W-1:0] PWMC_IDLE = 2'd0;
   localparam logic [PWMC_STATE_W-1:0] PWMC_ARM  = 2'd1;
   localparam logic [PWMC_STATE_W-1:0] PWMC_HIGH = 2'd2;
   localparam logic [PWMC_STATE_W-1:0] PWMC_LOW  = 2'd3;

endpackage

// File: rtl/pwm_input_sync.sv
// Synchroniser for the asynchronous PWM line plus a one-flop delay that
// turns the synchronised level into single-cycle rise/fall strobes.
module pwm_input_sync #(
   parameter int unsigned SyncStages = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pwm_i,
   output logic pwm_s_o,
   output logic rise_c_o,
   output logic fall_c_o
);

   logic [SyncStages-1:0] sync_q, sync_d;
   logic                  pwm_dly_q, pwm_dly_d;

   always_comb begin
      sync_d    = {sync_q[SyncStages-2:0], pwm_i};
      pwm_dly_d = sync_q[SyncStages-1];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q    <= '0;
         pwm_dly_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         pwm_dly_q <= pwm_dly_d;
      end
   end

   assign pwm_s_o  = sync_q[SyncStages-1];
   assign rise_c_o = sync_q[SyncStages-1] & ~pwm_dly_q;
   assign fall_c_o = ~sync_q[SyncStages-1] & pwm_dly_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures rise-to-rise period and rise-to-fall high time
// in clk_i cycles, with stuck-line timeout and sticky counter saturation.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int unsigned Resolution = PWM_RESOLUTION,
   parameter int unsigned SyncStages = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic                  pwm_i,
   input  logic [Resolution-1:0] timeout_i,
   input  logic                  clear_i,
   output logic [Resolution-1:0] period_o,
   output logic [Resolution-1:0] high_time_o,
   output logic                  valid_o,
   output logic                  stuck_o,
   output logic                  level_o,
   output logic                  overflow_o
);

   localparam logic [Resolution-1:0] CntMax = {Resolution{1'b1}};
   localparam logic [Resolution-1:0] CntOne = Resolution'(1);

   logic pwm_s, rise_c, fall_c;

   pwm_input_sync #(
      .SyncStages(SyncStages)
   ) u_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .pwm_i   (pwm_i),
      .pwm_s_o (pwm_s),
      .rise_c_o(rise_c),
      .fall_c_o(fall_c)
   );

   logic [PWMC_STATE_W-1:0] state_q, state_d;
   logic [Resolution-1:0]   per_cnt_q, per_cnt_d;
   logic [Resolution-1:0]   hi_cnt_q, hi_cnt_d;
   logic [Resolution-1:0]   hi_hold_q, hi_hold_d;
   logic [Resolution-1:0]   period_q, period_d;
   logic [Resolution-1:0]   high_time_q, high_time_d;
   logic                    valid_q, valid_d;
   logic                    stuck_q, stuck_d;
   logic                    overflow_q, overflow_d;

   logic                    per_sat_c, hi_sat_c, timeout_c, ovf_set_c;
   logic [Resolution-1:0]   per_inc_c, hi_inc_c;

   // Saturating increments; timeout only fires on a cycle with no line edge.
   always_comb begin
      per_sat_c = (per_cnt_q == CntMax);
      hi_sat_c  = (hi_cnt_q == CntMax);
      per_inc_c = per_sat_c ? per_cnt_q : per_cnt_q + CntOne;
      hi_inc_c  = hi_sat_c ? hi_cnt_q : hi_cnt_q + CntOne;
      timeout_c = (timeout_i != '0) && (per_cnt_q >= timeout_i) && !(rise_c || fall_c);
   end

   always_comb begin
      state_d     = state_q;
      per_cnt_d   = per_cnt_q;
      hi_cnt_d    = hi_cnt_q;
      hi_hold_d   = hi_hold_q;
      period_d    = period_q;
      high_time_d = high_time_q;
      valid_d     = 1'b0;
      stuck_d     = stuck_q;
      ovf_set_c   = 1'b0;

      if (!enable_i) begin
         state_d   = PWMC_IDLE;
         per_cnt_d = '0;
         hi_cnt_d  = '0;
         stuck_d   = 1'b0;
      end else begin
         case (state_q)
            PWMC_IDLE: begin
               state_d   = PWMC_ARM;
               per_cnt_d = '0;
               hi_cnt_d  = '0;
            end
            PWMC_ARM: begin
               if (rise_c) begin
                  per_cnt_d = CntOne;
                  hi_cnt_d  = CntOne;
                  state_d   = PWMC_HIGH;
               end else if (timeout_c) begin
                  stuck_d   = 1'b1;
                  per_cnt_d = CntOne;
               end else begin
                  per_cnt_d = per_inc_c;
                  ovf_set_c = per_sat_c;
               end
            end
            PWMC_HIGH: begin
               if (fall_c) begin
                  hi_hold_d = hi_cnt_q;
                  per_cnt_d = per_inc_c;
                  ovf_set_c = per_sat_c;
                  state_d   = PWMC_LOW;
               end else if (timeout_c) begin
                  stuck_d   = 1'b1;
                  per_cnt_d = CntOne;
                  state_d   = PWMC_ARM;
               end else begin
                  per_cnt_d = per_inc_c;
                  hi_cnt_d  = hi_inc_c;
                  ovf_set_c = per_sat_c | hi_sat_c;
               end
            end
            PWMC_LOW: begin
               if (rise_c) begin
                  period_d    = per_cnt_q;
                  high_time_d = hi_hold_q;
                  valid_d     = 1'b1;
                  stuck_d     = 1'b0;
                  per_cnt_d   = CntOne;
                  hi_cnt_d    = CntOne;
                  state_d     = PWMC_HIGH;
               end else if (timeout_c) begin
                  stuck_d   = 1'b1;
                  per_cnt_d = CntOne;
                  state_d   = PWMC_ARM;
               end else begin
                  per_cnt_d = per_inc_c;
                  ovf_set_c = per_sat_c;
               end
            end
            default: begin
               state_d = PWMC_IDLE;
            end
         endcase
      end

      // A new saturation beats a simultaneous clear.
      overflow_d = (overflow_q & ~clear_i) | ovf_set_c;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= PWMC_IDLE;
         per_cnt_q   <= '0;
         hi_cnt_q    <= '0;
         hi_hold_q   <= '0;
         period_q    <= '0;
         high_time_q <= '0;
         valid_q     <= 1'b0;
         stuck_q     <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         per_cnt_q   <= per_cnt_d;
         hi_cnt_q    <= hi_cnt_d;
         hi_hold_q   <= hi_hold_d;
         period_q    <= period_d;
         high_time_q <= high_time_d;
         valid_q     <= valid_d;
         stuck_q     <= stuck_d;
         overflow_q  <= overflow_d;
      end
   end

   assign period_o    = period_q;
   assign high_time_o = high_time_q;
   assign valid_o     = valid_q;
   assign stuck_o     = stuck_q;
   assign level_o     = pwm_s;
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: a timestamp-based reference model predicts every
// output cycle by cycle; an 8-bit instance covers counter saturation.
module tb_pwm_capture;

   localparam int unsigned SYNC = 2;
   localparam longint      MAX  = 64'h0000_0000_FFFF_FFFF;
   localparam int          PH_ARM = 1, PH_HIGH = 2, PH_LOW = 3;

   logic        clk = 1'b0;
   logic        rst, enable, pwm, clear;
   logic [31:0] timeout;
   logic [31:0] period, high_time;
   logic        valid, stuck, level, overflow;

   logic        en8, pwm8, clr8;
   logic [7:0]  to8 = 8'd0;
   logic [7:0]  period8, high8;
   logic        valid8, stuck8, level8, ovf8;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   pwm_capture #(.Resolution(32), .SyncStages(SYNC)) u_dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .pwm_i(pwm),
      .timeout_i(timeout), .clear_i(clear),
      .period_o(period), .high_time_o(high_time), .valid_o(valid),
      .stuck_o(stuck), .level_o(level), .overflow_o(overflow)
   );

   pwm_capture #(.Resolution(8), .SyncStages(SYNC)) u_dut8 (
      .clk_i(clk), .rst_i(rst), .enable_i(en8), .pwm_i(pwm8),
      .timeout_i(to8), .clear_i(clr8),
      .period_o(period8), .high_time_o(high8), .valid_o(valid8),
      .stuck_o(stuck8), .level_o(level8), .overflow_o(ovf8)
   );

   // Reference model: counts are differences of cycle timestamps, clipped at MAX.
   longint      cyc = 0, m_base = 0, m_rise = 0, m_hold = 0, m_per, m_hi;
   bit          m_active = 1'b0, m_s, m_re, m_fe, m_to, m_set, m_dly = 1'b0;
   bit [SYNC-1:0] m_line = '0;
   int          m_phase = PH_ARM;
   logic [31:0] e_period = '0, e_high = '0;
   bit          e_valid = 1'b0, e_stuck = 1'b0, e_ovf = 1'b0, e_level = 1'b0;

   wire [67:0] obs_vec = {valid, stuck, overflow, level, period, high_time};
   wire [67:0] exp_vec = {e_valid, e_stuck, e_ovf, e_level, e_period, e_high};

   always @(posedge clk) begin
      m_s   = m_line[SYNC-1];
      m_re  = m_s & ~m_dly;
      m_fe  = ~m_s & m_dly;
      m_per = cyc - m_base;
      if (m_per > MAX) m_per = MAX;
      m_hi  = cyc - m_rise;
      if (m_hi > MAX) m_hi = MAX;
      m_to  = (timeout != 0) && (m_per >= longint'(timeout)) && !(m_re || m_fe);
      m_set   = 1'b0;
      e_valid = 1'b0;
      if (rst) begin
         m_active = 1'b0;
         e_period = '0; e_high = '0; e_stuck = 1'b0; e_ovf = 1'b0;
      end else begin
         if (!enable) begin
            m_active = 1'b0;
            e_stuck  = 1'b0;
         end else if (!m_active) begin
            m_active = 1'b1;
            m_phase  = PH_ARM;
            m_base   = cyc + 1;
         end else begin
            case (m_phase)
               PH_ARM: begin
                  if (m_re) begin m_phase = PH_HIGH; m_base = cyc; m_rise = cyc; end
                  else if (m_to) begin e_stuck = 1'b1; m_base = cyc; end
                  else m_set = (m_per == MAX);
               end
               PH_HIGH: begin
                  if (m_fe) begin m_hold = m_hi; m_set = (m_per == MAX); m_phase = PH_LOW; end
                  else if (m_to) begin e_stuck = 1'b1; m_base = cyc; m_phase = PH_ARM; end
                  else m_set = (m_per == MAX) || (m_hi == MAX);
               end
               default: begin
                  if (m_re) begin
                     e_period = 32'(m_per); e_high = 32'(m_hold);
                     e_valid = 1'b1; e_stuck = 1'b0;
                     m_base = cyc; m_rise = cyc; m_phase = PH_HIGH;
                  end else if (m_to) begin e_stuck = 1'b1; m_base = cyc; m_phase = PH_ARM; end
                  else m_set = (m_per == MAX);
               end
            endcase
         end
         e_ovf = (e_ovf & ~clear) | m_set;
      end
      m_dly   = rst ? 1'b0 : m_s;
      m_line  = rst ? '0 : {m_line[SYNC-2:0], pwm};
      e_level = m_line[SYNC-1];
      cyc++;
   end

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; pwm = 1'b0; clear = 1'b0; timeout = '0;
      en8 = 1'b0; pwm8 = 1'b0; clr8 = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if ({period, high_time, valid, stuck, level, overflow} !== 68'd0)
         $display("FAIL reset_main got p=%0d h=%0d v%b s%b l%b o%b want all 0", period, high_time, valid, stuck, level, overflow);
      else n_pass++;
      n_total++;
      if ({period8, high8, valid8, stuck8, level8, ovf8} !== 20'd0)
         $display("FAIL reset_dut8 got p=%0d h=%0d v%b s%b l%b o%b want all 0", period8, high8, valid8, stuck8, level8, ovf8);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_steady();
      int nvalid = 0;
      enable = 1'b1; timeout = '0;
      repeat ($urandom_range(1, 7)) @(negedge clk);
      for (int c = 0; c < 100; c++) begin
         pwm = ((c % 10) < 3);
         @(negedge clk);
         n_total++;
         if (obs_vec !== exp_vec) $display("FAIL steady_cycle c=%0d got %h want %h", c, obs_vec, exp_vec);
         else n_pass++;
         if (valid) begin
            nvalid++;
            n_total++;
            if (period !== 32'd10 || high_time !== 32'd3 || stuck !== 1'b0)
               $display("FAIL steady_value got p=%0d h=%0d s%b want p=10 h=3 s0", period, high_time, stuck);
            else n_pass++;
         end
      end
      n_total++;
      if (nvalid !== 9) $display("FAIL steady_count got %0d pulses want 9", nvalid);
      else n_pass++;
   endtask

   task automatic test_extremes();
      for (int c = 0; c < 40; c++) begin
         pwm = ((c % 2) < 1);
         @(negedge clk);
         n_total++;
         if (obs_vec !== exp_vec) $display("FAIL p2_cycle c=%0d got %h want %h", c, obs_vec, exp_vec);
         else n_pass++;
      end
      n_total++;
      if (period !== 32'd2 || high_time !== 32'd1)
         $display("FAIL p2_value got p=%0d h=%0d want p=2 h=1", period, high_time);
      else n_pass++;
      for (int c = 0; c < 4004; c++) begin
         pwm = ((c % 2000) < 1999);
         @(negedge clk);
         n_total++;
         if (obs_vec !== exp_vec) $display("FAIL p2000_cycle c=%0d got %h want %h", c, obs_vec, exp_vec);
         else n_pass++;
      end
      n_total++;
      if (period !== 32'd2000 || high_time !== 32'd1999 || overflow !== 1'b0)
         $display("FAIL p2000_value got p=%0d h=%0d o%b want p=2000 h=1999 o0", period, high_time, overflow);
      else n_pass++;
   endtask

   task automatic test_stuck();
      int first_stuck = -1;
      int late_valid = 0;
      timeout = 32'd50;
      for (int c = 0; c < 30; c++) begin
         pwm = ((c % 10) < 5);
         @(negedge clk);
         n_total++;
         if (obs_vec !== exp_vec) $display("FAIL stuck_pre c=%0d got %h want %h", c, obs_vec, exp_vec);
         else n_pass++;
      end
      pwm = 1'b1;
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk);
         n_total++;
         if (obs_vec !== exp_vec) $display("FAIL stuck_hold i=%0d got %h want %h", i, obs_vec, exp_vec);
         else n_pass++;
         if (stuck && first_stuck < 0) first_stuck = i;
         if (i >= 4 && valid) late_valid++;
      end
      n_total++;
      if (first_stuck !== 50 + SYNC + 1)
         $display("FAIL stuck_latency got %0d want %0d", first_stuck, 50 + SYNC + 1);
      else n_pass++;
      n_total++;
      if (late_valid !== 0) $display("FAIL stuck_novalid got %0d pulses want 0", late_valid);
      else n_pass++;
      for (int c = 0; c < 50; c++) begin
         pwm = ((c % 10) < 5);
         @(negedge clk);
         n_total++;
         if (obs_vec !== exp_vec) $display("FAIL stuck_resume c=%0d got %h want %h", c, obs_vec, exp_vec);
         else n_pass++;
         if (c == 21) begin
            n_total++;
            if (stuck !== 1'b1 || valid !== 1'b0) $display("FAIL stuck_held got s%b v%b want s1 v0", stuck, valid);
            else n_pass++;
         end
         if (c == 22) begin
            n_total++;
            if (stuck !== 1'b0 || valid !== 1'b1 || period !== 32'd10 || high_time !== 32'd5)
               $display("FAIL stuck_clear got s%b v%b p=%0d h=%0d want s0 v1 p=10 h=5", stuck, valid, period, high_time);
            else n_pass++;
         end
      end
      timeout = '0;
   endtask

   task automatic test_reset_mid_high();
      for (int c = 0; c < 60; c++) begin
         pwm = ((c % 10) < 6);
         rst = (c == 33);
         @(negedge clk);
         n_total++;
         if (obs_vec !== exp_vec) $display("FAIL rstmid_cycle c=%0d got %h want %h", c, obs_vec, exp_vec);
         else n_pass++;
         if (c == 33) begin
            n_total++;
            if ({period, high_time, valid, stuck, level, overflow} !== 68'd0)
               $display("FAIL rstmid_zero got p=%0d h=%0d v%b s%b l%b o%b want all 0", period, high_time, valid, stuck, level, overflow);
            else n_pass++;
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_enable_drop();
      int win_valid = 0;
      for (int c = 0; c < 80; c++) begin
         pwm = ((c % 10) < 3);
         enable = !(c >= 45 && c < 48);
         @(negedge clk);
         n_total++;
         if (obs_vec !== exp_vec) $display("FAIL endrop_cycle c=%0d got %h want %h", c, obs_vec, exp_vec);
         else n_pass++;
         if (c >= 44 && c <= 61 && valid) win_valid++;
         if (c == 50) begin
            n_total++;
            if (period !== 32'd10 || high_time !== 32'd3 || stuck !== 1'b0)
               $display("FAIL endrop_hold got p=%0d h=%0d s%b want p=10 h=3 s0", period, high_time, stuck);
            else n_pass++;
         end
         if (c == 62) begin
            n_total++;
            if (valid !== 1'b1 || period !== 32'd10 || high_time !== 32'd3)
               $display("FAIL endrop_remeasure got v%b p=%0d h=%0d want v1 p=10 h=3", valid, period, high_time);
            else n_pass++;
         end
      end
      n_total++;
      if (win_valid !== 0) $display("FAIL endrop_novalid got %0d pulses want 0", win_valid);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         int p = $urandom_range(2, 40);
         int h = $urandom_range(1, p - 1);
         timeout = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(5, 60)) : 32'd0;
         for (int c = 0; c < p * 5; c++) begin
            pwm   = ((c % p) < h);
            clear = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            n_total++;
            if (obs_vec !== exp_vec)
               $display("FAIL random r=%0d P=%0d H=%0d c=%0d got %h want %h", r, p, h, c, obs_vec, exp_vec);
            else n_pass++;
         end
      end
      clear = 1'b0; timeout = '0;
   endtask

   task automatic test_saturation();
      int nv8 = 0;
      en8 = 1'b1;
      repeat (4) @(negedge clk);
      for (int p = 0; p < 4; p++) begin
         for (int j = 0; j < 300; j++) begin
            pwm8 = (j < 100);
            clr8 = (p == 1 && j == 280) || (p == 2 && j == 150);
            @(negedge clk);
            if (valid8) begin
               nv8++;
               n_total++;
               if (period8 !== 8'd255 || high8 !== 8'd100 || ovf8 !== 1'b1)
                  $display("FAIL sat_value got p=%0d h=%0d o%b want p=255 h=100 o1", period8, high8, ovf8);
               else n_pass++;
            end
            if (p == 1 && j == 280) begin
               n_total++;
               if (ovf8 !== 1'b1) $display("FAIL sat_clear_vs_set got o%b want o1", ovf8);
               else n_pass++;
            end
            if (p == 2 && j == 150) begin
               n_total++;
               if (ovf8 !== 1'b0) $display("FAIL sat_clear got o%b want o0", ovf8);
               else n_pass++;
            end
         end
      end
      clr8 = 1'b0;
      n_total++;
      if (nv8 !== 3 || ovf8 !== 1'b1) $display("FAIL sat_count got %0d pulses o%b want 3 pulses o1", nv8, ovf8);
      else n_pass++;
      en8 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_steady();
      test_extremes();
      test_stuck();
      test_reset_mid_high();
      test_enable_drop();
      test_random();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached after %0d of %0d checks", n_pass, n_total);
      $fatal(1);
   end

endmodule
